// File: rtl/phase_arbiter_if.sv
// phase_arbiter_if: request/grant and phase-output bundle for phase_arbiter.
//   req  : per-requester request lines (requester -> arbiter)
//   hold : pause, freezes an active sequence and blocks new grants
//   gnt  : one-hot grant or all zero (arbiter -> requester)
//   o    : 2-bit phase output
//   busy : high while a sequence is active
//   done : one-cycle pulse on entry to the final phase
// master = requester/environment side, slave = arbiter side.
interface phase_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic            hold;
  logic [NREQ-1:0] gnt;
  logic [1:0]      o;
  logic            busy;
  logic            done;

  modport master (output req, hold, input gnt, o, busy, done);
  modport slave  (input req, hold, output gnt, o, busy, done);
endinterface

// File: rtl/phase_arbiter.sv
// phase_arbiter: round-robin arbiter sharing a 4-phase sequencer
// (o = 01 -> 10 -> 11 -> 00) among NREQ requesters. Each grant runs one full
// phase sequence; re-arbitration happens in IDLE and in LAST (back-to-back).
// INV_ENC selects one-hot (0) or inverted one-hot (1) state codes; port
// behaviour is identical for both.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : phase_arbiter_if slave modport (req, hold in; gnt, o, busy, done out)
module phase_arbiter #(
  parameter int NREQ    = 4,
  parameter int INV_ENC = 0
) (
  input  logic           clk,
  input  logic           rst,
  phase_arbiter_if.slave bus
);
  localparam int         PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [4:0] ENC_MASK = (INV_ENC != 0) ? 5'b11111 : 5'b00000;

  typedef enum logic [4:0] {
    IDLE = 5'b00001 ^ ENC_MASK,
    PH1  = 5'b00010 ^ ENC_MASK,
    PH2  = 5'b00100 ^ ENC_MASK,
    PH3  = 5'b01000 ^ ENC_MASK,
    LAST = 5'b10000 ^ ENC_MASK
  } state_t;

  // Plain vector so corrupted (non-legal) codes are representable and recoverable.
  logic [4:0]      state;
  state_t          next_state;
  logic [PW-1:0]   ptr, ptr_n, win;
  logic            found;
  int unsigned     idx;
  logic [NREQ-1:0] gnt_q, gnt_n;
  logic [1:0]      o_q, o_n;
  logic            busy_q, busy_n;
  logic            done_q, done_n;

  // Round-robin search starting just after the last granted requester.
  always_comb begin : arb_search
    found = 1'b0;
    win   = ptr;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && bus.req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  always_comb begin : next_logic
    next_state = IDLE;
    gnt_n      = '0;
    ptr_n      = ptr;
    case (state)
      IDLE: begin
        if (!bus.hold && found) begin
          next_state = PH1;
          gnt_n      = NREQ'(1) << win;
          ptr_n      = win;
        end
      end
      PH1: begin
        next_state = bus.hold ? PH1 : PH2;
        gnt_n      = gnt_q;
      end
      PH2: begin
        next_state = bus.hold ? PH2 : PH3;
        gnt_n      = gnt_q;
      end
      PH3: begin
        next_state = bus.hold ? PH3 : LAST;
        gnt_n      = gnt_q;
      end
      LAST: begin
        if (bus.hold) begin
          next_state = LAST;
          gnt_n      = gnt_q;
        end else if (found) begin
          next_state = PH1;
          gnt_n      = NREQ'(1) << win;
          ptr_n      = win;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they carry
  // no combinational path from req/hold.
  always_comb begin : out_logic
    o_n    = '0;
    busy_n = 1'b0;
    case (next_state)
      PH1:     begin o_n = 2'b01; busy_n = 1'b1; end
      PH2:     begin o_n = 2'b10; busy_n = 1'b1; end
      PH3:     begin o_n = 2'b11; busy_n = 1'b1; end
      LAST:    begin o_n = 2'b00; busy_n = 1'b1; end
      default: begin o_n = 2'b00; busy_n = 1'b0; end
    endcase
    // Only on entry to LAST; a hold-frozen LAST keeps done low.
    done_n = (next_state == LAST) && (state != LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= PW'(NREQ - 1);
      gnt_q  <= '0;
      o_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      ptr    <= ptr_n;
      gnt_q  <= gnt_n;
      o_q    <= o_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.o    = o_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_phase_arbiter.sv
// tb_phase_arbiter: drives one-hot (INV_ENC=0) and inverted (INV_ENC=1)
// builds with identical stimulus and checks both against a sequence-level
// reference model (active flag, phase step, granted index, pointer).
module tb_phase_arbiter;
  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic            hold = 1'b0;

  int total = 0;
  int bad   = 0;

  phase_arbiter_if #(.NREQ(NREQ)) if0 ();
  phase_arbiter_if #(.NREQ(NREQ)) if1 ();

  assign if0.req  = req;
  assign if0.hold = hold;
  assign if1.req  = req;
  assign if1.hold = hold;

  phase_arbiter #(.NREQ(NREQ), .INV_ENC(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  phase_arbiter #(.NREQ(NREQ), .INV_ENC(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  // Reference model: a sequence is "active" with step 0..3 (PH1..LAST).
  int m_active, m_step, m_gidx, m_ptr;
  bit m_done, m_illegal;

  task automatic model_reset();
    m_active  = 0;
    m_step    = 0;
    m_gidx    = 0;
    m_ptr     = NREQ - 1;
    m_done    = 1'b0;
    m_illegal = 1'b0;
  endtask

  task automatic model_step();
    if (m_illegal) begin
      m_active  = 0;
      m_done    = 1'b0;
      m_illegal = 1'b0;
    end else if (hold) begin
      m_done = 1'b0;
    end else if (m_active == 0 || m_step == 3) begin
      m_active = 0;
      m_done   = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (req[c]) begin
          m_active = 1;
          m_step   = 0;
          m_gidx   = c;
          m_ptr    = c;
          break;
        end
      end
    end else begin
      m_step = m_step + 1;
      m_done = (m_step == 3);
    end
  endtask

  function automatic logic [7:0] exp_vec();
    logic [3:0] g;
    logic [1:0] ph;
    g  = (m_active != 0) ? 4'(1 << m_gidx) : 4'b0000;
    ph = (m_active != 0) ? 2'(m_step + 1) : 2'b00;
    return {g, ph, (m_active != 0), m_done};
  endfunction

  function automatic logic [7:0] obs0();
    return {if0.gnt, if0.o, if0.busy, if0.done};
  endfunction

  function automatic logic [7:0] obs1();
    return {if1.gnt, if1.o, if1.busy, if1.done};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst  = 1'b1;
    req  = '0;
    hold = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (obs0() !== 8'h00) begin
      bad++;
      $display("FAIL reset_enc0 got=%b want=%b", obs0(), 8'h00);
    end
    total++;
    if (obs1() !== 8'h00) begin
      bad++;
      $display("FAIL reset_enc1 got=%b want=%b", obs1(), 8'h00);
    end
  endtask

  task automatic test_single();
    int gcnt, dcnt;
    apply_reset();
    gcnt = 0;
    dcnt = 0;
    req = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      cycle();
      req = '0;
      if (if0.gnt != 0) gcnt++;
      if (if0.done) dcnt++;
      total++;
      if (obs0() !== exp_vec() || obs1() !== exp_vec()) begin
        bad++;
        $display("FAIL single_c%0d got0=%b got1=%b want=%b", i, obs0(), obs1(), exp_vec());
      end
    end
    total++;
    if (gcnt != 4 || dcnt != 1) begin
      bad++;
      $display("FAIL single_len gnt_cycles=%0d done=%0d want 4/1", gcnt, dcnt);
    end
  endtask

  task automatic test_all_req();
    int dcnt, last_done;
    logic [3:0] seq [0:4];
    apply_reset();
    dcnt = 0;
    last_done = -1;
    req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i % 4 == 0) seq[i / 4] = if0.gnt;
      if (if0.done) begin
        total++;
        if (last_done >= 0 && i - last_done != 4) begin
          bad++;
          $display("FAIL all_done_spacing got=%0d want=4", i - last_done);
        end
        last_done = i;
        dcnt++;
      end
      total++;
      if (obs0() !== exp_vec() || obs1() !== exp_vec()) begin
        bad++;
        $display("FAIL all_c%0d got0=%b got1=%b want=%b", i, obs0(), obs1(), exp_vec());
      end
    end
    total++;
    if (dcnt != 5) begin
      bad++;
      $display("FAIL all_done_count got=%0d want=5", dcnt);
    end
    total++;
    if ({seq[0], seq[1], seq[2], seq[3], seq[4]} !== 20'b0001_0010_0100_1000_0001) begin
      bad++;
      $display("FAIL all_order got=%b %b %b %b %b want=0001 0010 0100 1000 0001",
               seq[0], seq[1], seq[2], seq[3], seq[4]);
    end
    req = '0;
  endtask

  task automatic test_hold();
    int gcnt, dcnt;
    logic [3:0] g_ref;
    apply_reset();
    gcnt = 0;
    dcnt = 0;
    req = 4'b0001;
    cycle();                       // PH1
    if (if0.gnt != 0) gcnt++;
    req = '0;
    cycle();                       // PH2
    if (if0.gnt != 0) gcnt++;
    g_ref = if0.gnt;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (if0.gnt != 0) gcnt++;
      if (if0.done) dcnt++;
      total++;
      if (if0.o !== 2'b10 || if0.gnt !== 4'b0001 || obs0() !== exp_vec() || obs1() !== exp_vec()) begin
        bad++;
        $display("FAIL hold_c%0d got0=%b got1=%b want=%b", i, obs0(), obs1(), exp_vec());
      end
    end
    hold = 1'b0;
    cycle();
    if (if0.gnt != 0) gcnt++;
    total++;
    if (if0.o !== 2'b11 || obs1() !== exp_vec()) begin
      bad++;
      $display("FAIL hold_resume o=%b want=11", if0.o);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (if0.gnt != 0) gcnt++;
      if (if0.done) dcnt++;
    end
    total++;
    if (gcnt != 7 || dcnt != 1) begin
      bad++;
      $display("FAIL hold_len gnt_cycles=%0d done=%0d want 7/1", gcnt, dcnt);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req = 4'b0010;
    cycle();
    cycle();
    cycle();                       // now in PH3
    total++;
    if (if0.o !== 2'b11) begin
      bad++;
      $display("FAIL rstmid_pre o=%b want=11", if0.o);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (obs0() !== 8'h00 || obs1() !== 8'h00) begin
      bad++;
      $display("FAIL rstmid_async got0=%b got1=%b want=%b", obs0(), obs1(), 8'h00);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1000;
    cycle();
    total++;
    if (if0.gnt !== 4'b1000 || if1.gnt !== 4'b1000 || if0.done !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_regrant got0=%b got1=%b want=1000", if0.gnt, if1.gnt);
    end
    total++;
    if (obs0() !== exp_vec()) begin
      bad++;
      $display("FAIL rstmid_model got=%b want=%b", obs0(), exp_vec());
    end
    req = '0;
  endtask

  task automatic test_illegal();
    apply_reset();
    req = 4'b0100;
    cycle();
    cycle();                       // PH2
    force dut0.state = 5'b00011;
    force dut1.state = 5'b11100;
    #1;
    release dut0.state;
    release dut1.state;
    m_illegal = 1'b1;
    cycle();
    total++;
    if (obs0() !== 8'h00 || obs1() !== 8'h00 || obs0() !== exp_vec()) begin
      bad++;
      $display("FAIL illegal_recover got0=%b got1=%b want=%b", obs0(), obs1(), 8'h00);
    end
    req = 4'b0010;
    cycle();
    total++;
    if (if0.gnt !== 4'b0010 || if1.gnt !== 4'b0010 || obs0() !== exp_vec()) begin
      bad++;
      $display("FAIL illegal_rearb got0=%b got1=%b want=%b", obs0(), obs1(), exp_vec());
    end
    req = '0;
  endtask

  task automatic test_random_equiv();
    apply_reset();
    for (int i = 0; i < 1000; i++) begin
      req  = 4'($urandom_range(0, 15));
      hold = ($urandom_range(0, 3) == 0);
      cycle();
      total++;
      if (obs0() !== exp_vec() || obs1() !== exp_vec()) begin
        bad++;
        $display("FAIL rand_c%0d got0=%b got1=%b want=%b", i, obs0(), obs1(), exp_vec());
      end
    end
    req  = '0;
    hold = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_all_req();
    test_hold();
    test_reset_mid();
    test_illegal();
    test_random_equiv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/phase_arbiter.md
# phase_arbiter

Round-robin controller that shares the 4-phase output sequencer (o = 01 → 10 → 11 → 00) between up to NREQ requesters. Each grant runs exactly one full phase sequence. The arbiter then re-arbitrates, back-to-back if requests are pending. The internal state encoding is selectable (one-hot or inverted one-hot) and has no visible effect at the ports, so the two builds serve as a gold/gate pair for equivalence checking.

## Interface
Parameters:
- NREQ, default 4: number of requesters, range 2..8.
- INV_ENC, default 0: state encoding. 0 = one-hot; 1 = inverted one-hot. No effect at the ports.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset. Asynchronous, active-high.
- req  input  NREQ  request lines, one per requester; level-sensitive.
- hold  input  1  pause. Freezes an active sequence and blocks new grants.
- gnt  output  NREQ  one-hot grant, or all zero; registered.
- o  output  2  phase output; registered.
- busy  output  1  high while a sequence is active.
- done  output  1  single-cycle pulse in the final phase of a sequence.

## Operation
States: IDLE, PH1, PH2, PH3, LAST.
- Encoding with INV_ENC=0: 00001, 00010, 00100, 01000, 10000.
- Encoding with INV_ENC=1: bitwise inverse of the above.

Outputs per state:
- IDLE: o=00, gnt=0, busy=0, done=0.
- PH1: o=01. PH2: o=10. PH3: o=11.
- LAST: o=00, done=1.
- PH1..LAST: busy=1, gnt holds the granted requester.

Arbitration:
- Happens in IDLE, and in LAST when hold=0.
- Round-robin pointer ptr holds the index of the last granted requester.
- Search order: ptr+1, ptr+2, … modulo NREQ. The first requester with req=1 wins.
- If no req bit is set, no grant is made.

Transitions:
- IDLE, hold=0, any req=1 → PH1. gnt = winner; ptr = winner.
- IDLE, hold=1 or no req → stay in IDLE.
- PH1 → PH2 → PH3 → LAST, one step per cycle while hold=0.
- LAST, hold=0, any req=1 → PH1 with the new winner (back-to-back; the same requester may win again if it is the only one requesting).
- LAST, hold=0, no req → IDLE, gnt=0.
- hold=1 in any of PH1..LAST: state, o, gnt and busy freeze.
- done asserts only on the first cycle in LAST. It stays low while LAST is frozen by hold.

Request handling:
- req is sampled only when arbitration happens.
- A winner dropping req mid-sequence does not abort the sequence; it completes.
- A req pulse shorter than one arbitration cycle may be missed. Requesters hold req until they see gnt.

Illegal state:
- Any state register value other than the five legal codes → IDLE on the next clock.
- In that recovery cycle: o=00, gnt=0, done=0, busy=0.

Reset (rst=1):
- Immediately: state=IDLE, o=00, gnt=0, busy=0, done=0.
- ptr=NREQ-1, so req[0] has top priority after reset.
- Asserting reset mid-sequence aborts the sequence with no done pulse.
- After rst deasserts, the first arbitration happens on the first rising edge.

## Timing
- Edge t samples IDLE with req≠0 and hold=0. After edge t: gnt valid, o=01.
- After t+1: o=10. After t+2: o=11. After t+3: o=00 with done=1.
- A single sequence holds gnt for 4 cycles.
- Back-to-back grants: no idle cycle; LAST is followed directly by PH1.
- Throughput: one sequence per 4 cycles under continuous requests.
- Each hold cycle adds one cycle of latency. hold is sampled at the same edge as the transition it blocks.
- All outputs are registered. The path from req/hold to the outputs has no combinational component.
- Both INV_ENC settings must produce cycle-identical port behaviour.

## Test plan
- **Single request:** reset, then req=0001 held for one cycle (sampled at edge 1).
  - Required: gnt=0001 for 4 cycles; o=01,10,11,00; done high in the 4th cycle only; then IDLE with gnt=0.
- **All requesting:** req=1111 held continuously after reset.
  - Required: grants 0001, 0010, 0100, 1000, 0001, each lasting 4 cycles, with no gap.
  - Required: 5 done pulses, 4 cycles apart.
- **Hold:** hold=1 for 3 cycles while in PH2.
  - Required: o stays 10 and gnt stays stable for those 3 cycles; sequence resumes with o=11; total grant length 7 cycles; exactly one done pulse.
- **Reset mid-sequence:** assert rst while in PH3.
  - Required: o=00, gnt=0, busy=0 immediately; no done pulse.
  - Required: after release with req=1000, the grant goes to 1000 (ptr=3 after reset, so search order is 0,1,2,3 and only req[3] is set).
- **Illegal state:** force the state register to 00011 (or its inverse when INV_ENC=1).
  - Required: IDLE with o=00 and gnt=0 on the next cycle, then normal arbitration.
- **Encoding equivalence:** equivalence-check the INV_ENC=0 build against the INV_ENC=1 build; random req/hold stimulus for 1000 cycles.
  - Required: identical gnt, o, busy and done on every cycle.
